// File: rtl/wb_queue.sv
// wb_queue -- in-order writeback queue in front of the register file write port.
//
// Accepts completed results from the ALU and the load unit. Each has a
// valid/ready handshake, and a load wins when both arrive in the same cycle.
// Results are buffered in a DEPTH-entry FIFO. The FIFO drains one entry per
// cycle into the register file through we/wa/wd, and holds the head entry
// while wb_stall is high.
//
// Optional feature macro: WBQ_FWD_EN
//   defined   : combinational lookup of the youngest pending write to fwd_addr
//   undefined : fwd_hit/fwd_data tied to 0, fwd_addr ignored (ports unchanged)
//
// Parameters:
//   DATA_W  result/register data width
//   ADDR_W  register address width
//   DEPTH   number of queue entries (power of two, >= 2)
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid/alu_ready/addr/data   ALU result handshake and payload
//   mem_valid/mem_ready/addr/data   load result handshake and payload
//   wb_stall                        write port busy, hold the head entry
//   we, wa, wd                      register file write port
//   fwd_addr, fwd_hit, fwd_data     pending-write lookup
//   count, full, empty              registered occupancy status
module wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     wb_stall,
  output logic                     we,
  output logic [ADDR_W-1:0]        wa,
  output logic [DATA_W-1:0]        wd,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Entry storage carries no reset: the pointers and count define which
  // entries are live, and the outputs are gated by empty.
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_n;
  logic              full_q;
  logic              empty_q;

  logic              take_mem;
  logic              take_alu;
  logic              enq;
  logic              deq;
  logic [ADDR_W-1:0] enq_addr;
  logic [DATA_W-1:0] enq_data;

  // Enqueue arbitration: ready depends only on registered full and on
  // mem_valid, so a slot freed by a same-cycle dequeue is not reused until
  // the next cycle.
  assign mem_ready = !full_q;
  assign alu_ready = !full_q && !mem_valid;
  assign take_mem  = mem_valid && !full_q;
  assign take_alu  = alu_valid && alu_ready;
  assign enq       = take_mem || take_alu;
  assign enq_addr  = take_mem ? mem_addr : alu_addr;
  assign enq_data  = take_mem ? mem_data : alu_data;

  // Dequeue: the register file captures wa/wd on the same edge the head
  // advances.
  assign deq = !empty_q && !wb_stall;
  assign we  = deq;
  assign wa  = empty_q ? '0 : addr_q[head];
  assign wd  = empty_q ? '0 : data_q[head];

  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

  always_comb begin
    count_n = count_q;
    if (enq && !deq) begin
      count_n = count_q + CNT_W'(1);
    end else if (!enq && deq) begin
      count_n = count_q - CNT_W'(1);
    end
  end

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  // full/empty are registered from the next count so they track count exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (enq) begin
        tail <= tail + PTR_W'(1);
      end
      if (deq) begin
        head <= head + PTR_W'(1);
      end
      count_q <= count_n;
      full_q  <= (count_n == CNT_FULL);
      empty_q <= (count_n == '0);
    end
  end

  // Data storage.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= enq_addr;
      data_q[tail] <= enq_data;
    end
  end

`ifdef WBQ_FWD_EN
  // Forward lookup. Live entries are walked oldest to youngest and every
  // match overwrites the previous one, so the youngest match wins. This gives
  // the same result as scanning from tail-1 back to head and stopping at the
  // first hit. The lookup sees only registered entries, never the one being
  // enqueued this cycle.
  logic [PTR_W-1:0] scan_idx;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[scan_idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[scan_idx];
      end
    end
  end
`else
  logic unused_fwd_addr;

  assign unused_fwd_addr = ^fwd_addr;
  assign fwd_hit         = 1'b0;
  assign fwd_data        = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue -- self-checking bench for wb_queue.
// Directed steps followed by a randomized phase. Every cycle is compared with
// a queue-based reference model of the writeback FIFO.
module tb_wb_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clk;
  logic              rst_n;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              wb_stall;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  int checks   = 0;
  int failures = 0;
  ent_t q[$];

  wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_stall(wb_stall), .we(we), .wa(wa), .wd(wd),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference model for the current inputs.
  task automatic check_model();
    int sz;
    logic e_full;
    logic e_hit;
    logic [DATA_W-1:0] e_fdata;
    sz      = q.size();
    e_full  = (sz == DEPTH);
    e_hit   = 1'b0;
    e_fdata = '0;
`ifdef WBQ_FWD_EN
    for (int i = sz - 1; i >= 0; i--) begin
      if (q[i].a == fwd_addr) begin
        e_hit   = 1'b1;
        e_fdata = q[i].d;
        break;
      end
    end
`endif
    chk("count", 64'(count), 64'(sz));
    chk("full", 64'(full), 64'(e_full));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("mem_ready", 64'(mem_ready), 64'(!e_full));
    chk("alu_ready", 64'(alu_ready), 64'(!e_full && !mem_valid));
    chk("we", 64'(we), 64'(sz != 0 && !wb_stall));
    chk("wa", 64'(wa), 64'((sz != 0) ? q[0].a : '0));
    chk("wd", 64'(wd), 64'((sz != 0) ? q[0].d : '0));
    chk("fwd_hit", 64'(fwd_hit), 64'(e_hit));
    chk("fwd_data", 64'(fwd_data), 64'(e_fdata));
  endtask

  task automatic settle();
    @(negedge clk);
    check_model();
  endtask

  // Advance the model across the rising edge using the state before the edge.
  task automatic tick();
    logic pre_full;
    logic deq;
    @(posedge clk);
    pre_full = (q.size() == DEPTH);
    deq      = (q.size() != 0) && !wb_stall;
    if (deq) void'(q.pop_front());
    if (mem_valid && !pre_full) q.push_back({mem_addr, mem_data});
    else if (alu_valid && !pre_full) q.push_back({alu_addr, alu_data});
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    rst_n = 1'b0; alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0; wb_stall = 1'b0; fwd_addr = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_model();
    chk("rst_alu_ready", 64'(alu_ready), 64'(1));
    chk("rst_empty", 64'(empty), 64'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ALU result: written back the next cycle
    alu_valid = 1'b1; alu_addr = 6'd1; alu_data = 32'd11;
    step();
    alu_valid = 1'b0;
    settle();
    chk("t1_we", 64'(we), 64'(1));
    chk("t1_wa", 64'(wa), 64'(1));
    chk("t1_wd", 64'(wd), 64'(11));
    tick();
    settle();
    chk("t1_empty", 64'(empty), 64'(1));
    chk("t1_we_idle", 64'(we), 64'(0));
    tick();

    // mem over alu priority
    mem_valid = 1'b1; mem_addr = 6'd2; mem_data = 32'd25;
    alu_valid = 1'b1; alu_addr = 6'd3; alu_data = 32'd50;
    settle();
    chk("t2_mem_ready", 64'(mem_ready), 64'(1));
    chk("t2_alu_ready", 64'(alu_ready), 64'(0));
    tick();
    mem_valid = 1'b0;
    settle();
    chk("t2_wa0", 64'(wa), 64'(2));
    chk("t2_wd0", 64'(wd), 64'(25));
    tick();
    alu_valid = 1'b0;
    settle();
    chk("t2_wa1", 64'(wa), 64'(3));
    chk("t2_wd1", 64'(wd), 64'(50));
    tick();
    step();

    // Stalled fill: 5 attempts, 4 accepted
    wb_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'b1; alu_addr = ADDR_W'(i); alu_data = DATA_W'(10 + i);
      settle();
      if (i == 4) begin
        chk("t3_alu_ready_full", 64'(alu_ready), 64'(0));
        chk("t3_mem_ready_full", 64'(mem_ready), 64'(0));
        chk("t3_full", 64'(full), 64'(1));
        chk("t3_count", 64'(count), 64'(4));
        chk("t3_we_stall", 64'(we), 64'(0));
      end
      tick();
    end
    alu_valid = 1'b0; wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t3_drain_wa", 64'(wa), 64'(i));
      chk("t3_drain_wd", 64'(wd), 64'(10 + i));
      tick();
    end
    settle();
    chk("t3_empty", 64'(empty), 64'(1));
    tick();

    // Forward lookup on a stalled queue, then asynchronous reset with 3 entries
    wb_stall = 1'b1;
    alu_valid = 1'b1; alu_addr = 6'd5; alu_data = 32'd100; step();
    alu_addr = 6'd5; alu_data = 32'd200; step();
    alu_valid = 1'b0;
    fwd_addr = 6'd5;
    settle();
`ifdef WBQ_FWD_EN
    chk("t4_hit5", 64'(fwd_hit), 64'(1));
    chk("t4_data5", 64'(fwd_data), 64'(200));
`else
    chk("t4_hit5_off", 64'(fwd_hit), 64'(0));
    chk("t4_data5_off", 64'(fwd_data), 64'(0));
`endif
    tick();
    fwd_addr = 6'd6;
    settle();
    chk("t4_hit6", 64'(fwd_hit), 64'(0));
    chk("t4_data6", 64'(fwd_data), 64'(0));
    tick();
    alu_valid = 1'b1; alu_addr = 6'd7; alu_data = 32'd300; fwd_addr = 6'd7;
    step();
    alu_valid = 1'b0; wb_stall = 1'b0;
    settle();
    chk("t5_pre_count", 64'(count), 64'(3));
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("t5_we", 64'(we), 64'(0));
    chk("t5_count", 64'(count), 64'(0));
    chk("t5_empty", 64'(empty), 64'(1));
    chk("t5_fwd_hit", 64'(fwd_hit), 64'(0));
    chk("t5_wa", 64'(wa), 64'(0));
    chk("t5_wd", 64'(wd), 64'(0));
    @(posedge clk);
    @(negedge clk);
    check_model();
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t5_no_stale_we", 64'(we), 64'(0));
      tick();
    end

    // Full queue, mem_valid held, stall released
    wb_stall = 1'b1; mem_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 5) wb_stall = 1'b0;
      mem_addr = ADDR_W'($urandom_range(0, 63));
      mem_data = $urandom;
      step();
    end
    mem_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      mem_valid = ($urandom_range(0, 3) == 0);
      alu_valid = ($urandom_range(0, 1) == 0);
      wb_stall  = ($urandom_range(0, 9) < 3);
      mem_addr  = ADDR_W'($urandom_range(0, 7));
      alu_addr  = ADDR_W'($urandom_range(0, 7));
      mem_data  = $urandom;
      alu_data  = $urandom;
      fwd_addr  = ADDR_W'($urandom_range(0, 7));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
# wb_queue

Writeback queue sitting directly upstream of the register file write port. It accepts completed results from the ALU and memory units through valid/ready handshakes and buffers them in a small in-order FIFO. It drives the register file's `we`/`wa`/`wd` one entry per cycle, and holds entries while writeback is stalled. An optional lookup port lets the operand-read side forward data from writes that are still pending.

## Interface
Parameters:
- `DATA_W`, 32: result/register data width.
- `ADDR_W`, 6: register address width.
- `DEPTH`, 4: queue entries; power of two, ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `alu_valid`  in  1  ALU result present.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `alu_addr`  in  ADDR_W  ALU destination register.
- `alu_data`  in  DATA_W  ALU result.
- `mem_valid`  in  1  load result present.
- `mem_ready`  out  1  load result accepted this cycle.
- `mem_addr`  in  ADDR_W  load destination register.
- `mem_data`  in  DATA_W  load data.
- `wb_stall`  in  1  write port unavailable; hold the head entry.
- `we`  out  1  register file write enable.
- `wa`  out  ADDR_W  register file write address.
- `wd`  out  DATA_W  register file write data.
- `fwd_addr`  in  ADDR_W  operand address to look up.
- `fwd_hit`  out  1  a pending write to `fwd_addr` exists.
- `fwd_data`  out  DATA_W  data of the youngest pending write to `fwd_addr`.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.

## Operation
- The FIFO uses head/tail pointers that wrap modulo DEPTH, plus a registered `count`. Each entry holds {addr, data}.
- Enqueue:
  - At most one enqueue per cycle, with fixed priority: mem over alu.
  - `mem_ready = !full`.
  - `alu_ready = !full && !mem_valid`.
  - A handshake completes when valid && ready; the entry is written at the tail on the rising edge.
- Dequeue:
  - `we = !empty && !wb_stall`.
  - `wa`/`wd` are the head entry when `!empty`, and 0 when empty.
  - When `we == 1`, head advances at the rising edge (the register file captures on the same edge).
- Simultaneous enqueue and dequeue: `count` is unchanged and both pointers advance.
- Full: no enqueue, even if a dequeue occurs the same cycle (ready is computed from registered `full` only).
- Empty: no dequeue; `we == 0` regardless of `wb_stall`.
- Order is strictly in acceptance order. Writes to the same address reach the register file oldest-first.
- Address 0 gets no special treatment; it is queued and written like any other.
- Forward lookup (combinational):
  - Scans the valid entries from tail-1 back to head.
  - `fwd_hit = 1` on the first address match, with `fwd_data` from that entry.
  - Otherwise `fwd_hit = 0` and `fwd_data = 0`.
  - Entries being enqueued in the current cycle are not visible to the lookup.
- Reset (asynchronous, any time, including mid-drain):
  - Pointers and `count` go to 0, and the contents are discarded.
  - Outputs: `we=0`, `wa=0`, `wd=0`, `alu_ready=1`, `mem_ready=1`, `fwd_hit=0`, `fwd_data=0`, `count=0`, `full=0`, `empty=1`.

## Timing
- Latency: a result accepted at edge E appears on `we`/`wa`/`wd` during the cycle after E. It is written to the register file at edge E+1 if `wb_stall == 0`.
- Throughput: one enqueue and one writeback per cycle in steady state.
- `wb_stall` is sampled combinationally. Holding it high freezes the head; `we` is 0 for the whole stall.
- `full`, `empty` and `count` are registered and change only on clock edges or reset.
- Ready signals depend on `full` and `mem_valid` only, never on `alu_valid`.

## Configuration
- `WBQ_FWD_EN` defined: the forward lookup logic is compiled in and behaves as described above.
- `WBQ_FWD_EN` undefined:
  - The lookup logic is removed.
  - `fwd_hit` and `fwd_data` are tied to 0; `fwd_addr` is ignored.
  - Ports are unchanged.

## Test plan
- Reset, then `alu_valid=1`, `alu_addr=1`, `alu_data=11` for one cycle with `wb_stall=0` -> the next cycle shows `we=1`, `wa=1`, `wd=11`; after that `empty=1` and `we=0`.
- `mem_valid` and `alu_valid` both high (mem: addr 2, data 25; alu: addr 3, data 50) -> `mem_ready=1`, `alu_ready=0`. Holding alu valid, the following writebacks are (2,25) then (3,50).
- `wb_stall=1` with 5 enqueue attempts (addrs 0–4, data 10–14) -> 4 accepted, `full=1`, `count=4`, ready low, `we=0`. Release stall -> writebacks (0,10), (1,11), (2,12), (3,13) in order, with `empty=1` after the fourth.
- `WBQ_FWD_EN` on, stalled queue holding (5,100) then (5,200), `fwd_addr=5` -> `fwd_hit=1`, `fwd_data=200`. With `fwd_addr=6` -> `fwd_hit=0`, `fwd_data=0`.
- Queue with 3 entries, assert `rst_n=0` mid-cycle -> immediately `we=0`, `count=0`, `empty=1`, `fwd_hit=0`. After release, no stale writebacks occur.
- Full queue with `wb_stall=0` and `mem_valid` held -> one entry is popped per cycle, a new entry is accepted only on cycles where `full` was 0 at the preceding edge, and no data is lost or duplicated.
